// File: rtl/pll_reconf_pkg.sv
// Shared state encoding, default parameters and sizing helper for the PLL
// reconfiguration sequencer.
package pll_reconf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StStep,
    StWaitRdy,
    StFault
  } pll_reconf_state_e;

  localparam int unsigned DefOptW       = 3;
  localparam int unsigned DefSettleCyc  = 8;
  localparam int unsigned DefTimeoutCyc = 4096;
  localparam int unsigned DefMaxRetries = 2;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned cnt_w(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pll_reconf_timer.sv
// Clearable saturating up-counter; tc_o flags that the count has reached Limit-1.
module pll_reconf_timer
  import pll_reconf_pkg::*;
#(
  parameter int unsigned Limit = DefSettleCyc
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = cnt_w(Limit);
  localparam logic [W-1:0] Last = W'(Limit - 1);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != Last)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == Last);

endmodule

// File: rtl/pll_reconf_sequencer.sv
// Debounces configuration requests and sequences PLL DRP reconfiguration with
// timeout, bounded retries and a sticky fault; holds downstream reset while busy.
module pll_reconf_sequencer
  import pll_reconf_pkg::*;
#(
  parameter int unsigned OPT_W       = DefOptW,
  parameter int unsigned SETTLE_CYC  = DefSettleCyc,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc,
  parameter int unsigned MAX_RETRIES = DefMaxRetries
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPT_W-1:0] option_req,
  input  logic             force_reconf,
  input  logic             srdy,
  output logic             sstep,
  output logic [OPT_W-1:0] state_sel,
  output logic [OPT_W-1:0] applied_option,
  output logic             busy,
  output logic             sys_reset_out,
  output logic             timeout_err
);

  localparam int unsigned RW = cnt_w(MAX_RETRIES + 1);
  localparam logic [RW-1:0] MaxRetry = RW'(MAX_RETRIES);

  pll_reconf_state_e state_d, state_q;
  logic [OPT_W-1:0]  target_d, target_q;
  logic [OPT_W-1:0]  applied_d, applied_q;
  logic [RW-1:0]     retry_d, retry_q;
  logic              err_d, err_q;

  logic settle_clr, settle_en, settle_tc;
  logic tmo_clr, tmo_tc;

  pll_reconf_timer #(
    .Limit (SETTLE_CYC)
  ) u_settle_timer (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (settle_clr),
    .en_i  (settle_en),
    .tc_o  (settle_tc)
  );

  pll_reconf_timer #(
    .Limit (TIMEOUT_CYC)
  ) u_timeout_timer (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (tmo_clr),
    .en_i  (1'b1),
    .tc_o  (tmo_tc)
  );

  // Timeout window restarts on every entry to WAIT_RDY, including retries.
  assign tmo_clr = (state_q != StWaitRdy);

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    applied_d  = applied_q;
    retry_d    = retry_q;
    err_d      = err_q;
    settle_clr = 1'b1;
    settle_en  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (force_reconf || (option_req != applied_q)) begin
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (option_req != target_q) begin
          target_d = option_req;
        end else begin
          settle_clr = 1'b0;
          settle_en  = 1'b1;
          // settle_tc here means this is the last required stable cycle.
          if (settle_tc) begin
            state_d = StStep;
          end
        end
      end
      StStep: begin
        state_d = StWaitRdy;
      end
      StWaitRdy: begin
        if (srdy) begin
          applied_d = target_q;
          retry_d   = '0;
          state_d   = (option_req != target_q) ? StSettle : StIdle;
        end else if (tmo_tc) begin
          if (retry_q < MaxRetry) begin
            retry_d = retry_q + RW'(1);
            state_d = StStep;
          end else begin
            err_d   = 1'b1;
            state_d = StFault;
          end
        end
      end
      StFault: begin
        if (force_reconf || (option_req != target_q)) begin
          err_d   = 1'b0;
          retry_d = '0;
          state_d = StSettle;
        end
      end
      default: begin
        state_d = StSettle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StSettle;
      target_q  <= '0;
      applied_q <= '0;
      retry_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      applied_q <= applied_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
    end
  end

  assign sstep          = (state_q == StStep);
  assign busy           = (state_q == StSettle) || (state_q == StStep) || (state_q == StWaitRdy);
  assign sys_reset_out  = (state_q != StIdle);
  assign state_sel      = target_q;
  assign applied_option = applied_q;
  assign timeout_err    = err_q;

endmodule

// File: tb/tb_pll_reconf_sequencer.sv
// Directed bench for pll_reconf_sequencer with SETTLE_CYC=8, TIMEOUT_CYC=16,
// MAX_RETRIES=2; inputs change and outputs are checked 1ns after each rising edge.
module tb_pll_reconf_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] option_req;
  logic       force_reconf;
  logic       srdy;
  logic       sstep;
  logic [2:0] state_sel;
  logic [2:0] applied_option;
  logic       busy;
  logic       sys_reset_out;
  logic       timeout_err;

  int total = 0;
  int bad = 0;
  int n_sstep = 0;
  int snap;

  pll_reconf_sequencer #(
    .OPT_W       (3),
    .SETTLE_CYC  (8),
    .TIMEOUT_CYC (16),
    .MAX_RETRIES (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .option_req     (option_req),
    .force_reconf   (force_reconf),
    .srdy           (srdy),
    .sstep          (sstep),
    .state_sel      (state_sel),
    .applied_option (applied_option),
    .busy           (busy),
    .sys_reset_out  (sys_reset_out),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sstep) n_sstep++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after the edge that starts the stable window (target loaded,
  // reset released or force accepted); expects sstep on the 8th edge.
  task automatic settle_to_step(input string tag, input logic [2:0] sel);
    repeat (7) tick();
    check({tag, "_pre_sstep"}, sstep, 1'b0);
    tick();
    check({tag, "_sstep"}, sstep, 1'b1);
    check({tag, "_sel"}, state_sel, sel);
  endtask

  initial begin
    rst = 1'b1;
    option_req = 3'd5;
    force_reconf = 1'b0;
    srdy = 1'b0;
    repeat (3) tick();
    check("rst_sstep", sstep, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_sysrst", sys_reset_out, 1'b1);
    check("rst_err", timeout_err, 1'b0);
    check("rst_sel", state_sel, 3'd0);
    check("rst_applied", applied_option, 3'd0);

    // Boot sequence
    option_req = 3'd0;
    rst = 1'b0;
    settle_to_step("boot", 3'd0);
    repeat (4) tick();
    check("boot_wait_busy", busy, 1'b1);
    srdy = 1'b1;
    tick();
    srdy = 1'b0;
    check("boot_busy", busy, 1'b0);
    check("boot_sysrst", sys_reset_out, 1'b0);
    check("boot_applied", applied_option, 3'd0);

    // Stray srdy in IDLE
    snap = n_sstep;
    srdy = 1'b1;
    tick();
    srdy = 1'b0;
    repeat (3) tick();
    check("stray_busy", busy, 1'b0);
    check("stray_sstep_cnt", n_sstep, snap);

    // Debounce: 0 -> 3, then 5 two cycles later
    snap = n_sstep;
    option_req = 3'd3;
    tick();
    check("deb_busy", busy, 1'b1);
    check("deb_sel0", state_sel, 3'd0);
    tick();
    check("deb_sel3", state_sel, 3'd3);
    option_req = 3'd5;
    tick();
    check("deb_sel5", state_sel, 3'd5);
    settle_to_step("deb", 3'd5);
    tick();
    srdy = 1'b1;
    tick();
    srdy = 1'b0;
    check("deb_applied", applied_option, 3'd5);
    check("deb_idle", busy, 1'b0);
    check("deb_one_sstep", n_sstep, snap + 1);

    // Change during WAIT_RDY
    option_req = 3'd1;
    tick();
    tick();
    settle_to_step("chg1", 3'd1);
    tick();
    option_req = 3'd2;
    tick();
    srdy = 1'b1;
    tick();
    srdy = 1'b0;
    check("chg_applied1", applied_option, 3'd1);
    check("chg_busy", busy, 1'b1);
    check("chg_sel_hold", state_sel, 3'd1);
    tick();
    check("chg_sel2", state_sel, 3'd2);
    settle_to_step("chg2", 3'd2);
    tick();
    srdy = 1'b1;
    tick();
    srdy = 1'b0;
    check("chg_applied2", applied_option, 3'd2);

    // Timeout, retries, fault, force recovery
    option_req = 3'd6;
    tick();
    tick();
    settle_to_step("tmo1", 3'd6);
    for (int r = 2; r <= 3; r++) begin
      repeat (16) tick();
      check($sformatf("tmo%0d_gap", r), sstep, 1'b0);
      tick();
      check($sformatf("tmo%0d_sstep", r), sstep, 1'b1);
    end
    repeat (16) tick();
    check("tmo_nofault_yet", timeout_err, 1'b0);
    tick();
    check("fault_err", timeout_err, 1'b1);
    check("fault_busy", busy, 1'b0);
    check("fault_sysrst", sys_reset_out, 1'b1);
    snap = n_sstep;
    repeat (5) tick();
    check("fault_sticky", timeout_err, 1'b1);
    check("fault_quiet", n_sstep, snap);
    force_reconf = 1'b1;
    tick();
    force_reconf = 1'b0;
    check("fault_exit_err", timeout_err, 1'b0);
    check("fault_exit_busy", busy, 1'b1);
    settle_to_step("refault", 3'd6);
    tick();
    srdy = 1'b1;
    tick();
    srdy = 1'b0;
    check("recover_applied", applied_option, 3'd6);
    check("recover_idle", busy, 1'b0);

    // force_reconf in IDLE with unchanged option
    force_reconf = 1'b1;
    tick();
    force_reconf = 1'b0;
    check("force_busy", busy, 1'b1);
    settle_to_step("force", 3'd6);

    // Reset during WAIT_RDY
    repeat (3) tick();
    snap = n_sstep;
    option_req = 3'd3;
    rst = 1'b1;
    #1;
    check("midrst_sel", state_sel, 3'd0);
    check("midrst_applied", applied_option, 3'd0);
    check("midrst_busy", busy, 1'b1);
    repeat (4) tick();
    check("midrst_no_sstep", n_sstep, snap);
    rst = 1'b0;
    tick();
    check("restart_sel", state_sel, 3'd3);
    settle_to_step("restart", 3'd3);
    tick();
    srdy = 1'b1;
    tick();
    srdy = 1'b0;
    check("restart_applied", applied_option, 3'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
